// File: rtl/layer_driver.sv
// layer_driver: sequences clear, run and result handshakes between a sample stream and a compute layer
module layer_driver #(
  parameter int WIDTH      = 8,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x0,
  input  logic signed [WIDTH-1:0] in_x1,
  output logic                    layer_req,
  output logic                    layer_rst,
  input  logic                    layer_idx,
  output logic signed [WIDTH-1:0] layer_x,
  input  logic                    layer_ack,
  input  logic signed [WIDTH-1:0] layer_a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_a,
  output logic                    timeout_err,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, OUT, ABORT} state_t;
  state_t                  r_state, w_next;
  logic                    r_live;
  logic [15:0]             r_cnt, w_cnt;
  logic signed [WIDTH-1:0] r_x0, r_x1, r_a;
  logic                    r_terr;
  logic                    w_accept, w_clr_done, w_timeout;
  assign w_accept    = r_live && r_state == IDLE && in_valid;
  assign w_clr_done  = r_cnt == 16'(CLR_CYCLES);
  assign w_timeout   = r_cnt == 16'(TIMEOUT);
  assign in_ready    = r_live && r_state == IDLE;
  assign layer_rst   = !r_live || r_state == CLEAR || r_state == ABORT;
  assign layer_req   = r_state == RUN;
  assign out_valid   = r_state == OUT;
  assign busy        = r_state != IDLE;
  assign layer_x     = layer_idx ? r_x1 : r_x0;
  assign out_a       = r_a;
  assign timeout_err = r_terr;
  // next state; r_cnt counts clear cycles in CLEAR/ABORT and run cycles in RUN, ack beats timeout
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE:    if (w_accept) begin w_next = CLEAR; w_cnt = 16'd1; end
      CLEAR:   if (w_clr_done) begin w_next = RUN; w_cnt = 16'd1; end else w_cnt = r_cnt + 16'd1;
      RUN:     if (layer_ack) w_next = OUT;
               else if (w_timeout) begin w_next = ABORT; w_cnt = 16'd1; end
               else w_cnt = r_cnt + 16'd1;
      OUT:     if (out_ready) w_next = IDLE;
      ABORT:   if (w_clr_done) w_next = IDLE; else w_cnt = r_cnt + 16'd1;
      default: w_next = IDLE;
    endcase
  end
  // state, operand, result and error registers; r_live holds the layer in clear until the first clock after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_a     <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_x0   <= in_x0;
        r_x1   <= in_x1;
        r_terr <= 1'b0;
      end
      if (r_state == RUN && layer_ack) r_a <= layer_a;
      if (r_state == RUN && !layer_ack && w_timeout) r_terr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_layer_driver.sv
// tb_layer_driver: directed checks of the layer driver, default instance A and TIMEOUT=4 instance B
module tb_layer_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [7:0] in_x0 = '0, in_x1 = '0, layer_a = '0;
  logic layer_idx = 1'b0, out_ready = 1'b0;
  logic a_in_valid = 1'b0, a_layer_ack = 1'b0, b_in_valid = 1'b0, b_layer_ack = 1'b0;
  logic a_in_ready, a_layer_req, a_layer_rst, a_out_valid, a_terr, a_busy;
  logic b_in_ready, b_layer_req, b_layer_rst, b_out_valid, b_terr, b_busy;
  logic signed [7:0] a_layer_x, a_out_a, b_layer_x, b_out_a;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer_driver dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .layer_req(a_layer_req), .layer_rst(a_layer_rst),
    .layer_idx(layer_idx), .layer_x(a_layer_x), .layer_ack(a_layer_ack), .layer_a(layer_a),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_a(a_out_a),
    .timeout_err(a_terr), .busy(a_busy)
  );

  layer_driver #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .layer_req(b_layer_req), .layer_rst(b_layer_rst),
    .layer_idx(layer_idx), .layer_x(b_layer_x), .layer_ack(b_layer_ack), .layer_a(layer_a),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_a(b_out_a),
    .timeout_err(b_terr), .busy(b_busy)
  );

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (a_layer_rst !== 1'b1) begin errors++; $display("FAIL reset layer_rst got %b want 1", a_layer_rst); end
    checks++; if (a_layer_req !== 1'b0) begin errors++; $display("FAIL reset layer_req got %b want 0", a_layer_req); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b want 0", a_in_ready); end
    checks++; if (a_out_a !== 8'h00) begin errors++; $display("FAIL reset out_a got %h want 00", a_out_a); end
    checks++; if (a_terr !== 1'b0) begin errors++; $display("FAIL reset timeout_err got %b want 0", a_terr); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", a_busy); end
    checks++; if (a_layer_x !== 8'h00) begin errors++; $display("FAIL reset layer_x got %h want 00", a_layer_x); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (a_layer_rst !== 1'b0) begin errors++; $display("FAIL reset_release layer_rst got %b want 0", a_layer_rst); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready got %b want 1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release b in_ready got %b want 1", b_in_ready); end
  endtask

  task automatic test_basic();
    logic e;
    in_x0 = 8'sd16; in_x1 = -8'sd8; layer_a = 8'h2A; layer_idx = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      a_in_valid = (c == 0);
      a_layer_ack = (c == 9);
      out_ready = (c == 10);
      #1;
      e = (c >= 1 && c <= 2);
      checks++; if (a_layer_rst !== e) begin errors++; $display("FAIL basic c=%0d layer_rst got %b want %b", c, a_layer_rst, e); end
      e = (c >= 3 && c <= 9);
      checks++; if (a_layer_req !== e) begin errors++; $display("FAIL basic c=%0d layer_req got %b want %b", c, a_layer_req, e); end
      e = (c == 10);
      checks++; if (a_out_valid !== e) begin errors++; $display("FAIL basic c=%0d out_valid got %b want %b", c, a_out_valid, e); end
      e = (c == 0 || c == 11);
      checks++; if (a_in_ready !== e) begin errors++; $display("FAIL basic c=%0d in_ready got %b want %b", c, a_in_ready, e); end
      if (c == 10) begin
        checks++; if (a_out_a !== 8'h2A) begin errors++; $display("FAIL basic out_a got %h want 2a", a_out_a); end
      end
      if (c == 5) begin
        checks++; if (a_layer_x !== 8'h10) begin errors++; $display("FAIL basic layer_x got %h want 10", a_layer_x); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mux();
    logic [7:0] ex;
    in_x0 = 8'h10; in_x1 = 8'hF8; layer_a = 8'h55;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      a_in_valid = (c == 0);
      a_layer_ack = (c == 7);
      out_ready = (c == 8);
      layer_idx = c[0];
      #1;
      if (c >= 1) begin
        ex = c[0] ? 8'hF8 : 8'h10;
        checks++; if (a_layer_x !== ex) begin errors++; $display("FAIL mux c=%0d layer_x got %h want %h", c, a_layer_x, ex); end
      end
      if (c == 8) begin
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL mux out_valid got %b want 1", a_out_valid); end
        checks++; if (a_out_a !== 8'h55) begin errors++; $display("FAIL mux out_a got %h want 55", a_out_a); end
      end
    end
    out_ready = 1'b0; layer_idx = 1'b0;
  endtask

  task automatic test_backpressure();
    in_x0 = 8'h21; in_x1 = 8'h22; layer_idx = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      a_in_valid = (c == 0 || c == 6);
      a_layer_ack = (c == 3);
      out_ready = (c == 9);
      if (c == 3) layer_a = 8'hFD;
      if (c == 4) layer_a = 8'h00;
      if (c == 6) in_x0 = 8'h77;
      #1;
      if (c >= 4 && c <= 9) begin
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL backpressure c=%0d out_valid got %b want 1", c, a_out_valid); end
        checks++; if (a_out_a !== 8'hFD) begin errors++; $display("FAIL backpressure c=%0d out_a got %h want fd", c, a_out_a); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL backpressure c=%0d in_ready got %b want 0", c, a_in_ready); end
      end
      if (c == 10) begin
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL backpressure idle in_ready got %b want 1", a_in_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL backpressure idle busy got %b want 0", a_busy); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL backpressure idle out_valid got %b want 0", a_out_valid); end
        checks++; if (a_layer_x !== 8'h21) begin errors++; $display("FAIL backpressure held x0 got %h want 21", a_layer_x); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic e;
    in_x0 = 8'h01; in_x1 = 8'h02;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      b_in_valid = (c == 0);
      b_layer_ack = 1'b0;
      #1;
      e = (c >= 3 && c <= 6);
      checks++; if (b_layer_req !== e) begin errors++; $display("FAIL timeout c=%0d layer_req got %b want %b", c, b_layer_req, e); end
      e = (c >= 1 && c <= 2) || (c >= 7 && c <= 8);
      checks++; if (b_layer_rst !== e) begin errors++; $display("FAIL timeout c=%0d layer_rst got %b want %b", c, b_layer_rst, e); end
      e = (c >= 7);
      checks++; if (b_terr !== e) begin errors++; $display("FAIL timeout c=%0d timeout_err got %b want %b", c, b_terr, e); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL timeout c=%0d out_valid got %b want 0", c, b_out_valid); end
      e = (c == 0 || c == 9);
      checks++; if (b_in_ready !== e) begin errors++; $display("FAIL timeout c=%0d in_ready got %b want %b", c, b_in_ready, e); end
    end
  endtask

  task automatic test_coincide();
    logic e;
    layer_a = 8'h81;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      b_in_valid = (c == 0);
      b_layer_ack = (c == 1 || c == 2 || c == 6);
      out_ready = (c == 7);
      #1;
      e = (c == 0);
      checks++; if (b_terr !== e) begin errors++; $display("FAIL coincide c=%0d timeout_err got %b want %b", c, b_terr, e); end
      e = (c >= 3 && c <= 6);
      checks++; if (b_layer_req !== e) begin errors++; $display("FAIL coincide c=%0d layer_req got %b want %b", c, b_layer_req, e); end
      e = (c == 7);
      checks++; if (b_out_valid !== e) begin errors++; $display("FAIL coincide c=%0d out_valid got %b want %b", c, b_out_valid, e); end
      if (c == 7) begin
        checks++; if (b_out_a !== 8'h81) begin errors++; $display("FAIL coincide out_a got %h want 81", b_out_a); end
      end
      if (c == 8) begin
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL coincide in_ready got %b want 1", b_in_ready); end
      end
    end
    out_ready = 1'b0; b_layer_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_x0 = 8'h33; in_x1 = 8'h44; layer_idx = 1'b0; layer_a = 8'h66;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      a_in_valid = (c == 0);
      a_layer_ack = (c == 4);
      rst = (c != 4);
      #1;
      if (c == 3) begin
        checks++; if (a_layer_req !== 1'b1) begin errors++; $display("FAIL reset_mid pre layer_req got %b want 1", a_layer_req); end
      end
      if (c == 4) begin
        checks++; if (a_layer_req !== 1'b0) begin errors++; $display("FAIL reset_mid layer_req got %b want 0", a_layer_req); end
        checks++; if (a_layer_rst !== 1'b1) begin errors++; $display("FAIL reset_mid layer_rst got %b want 1", a_layer_rst); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", a_busy); end
        checks++; if (a_out_a !== 8'h00) begin errors++; $display("FAIL reset_mid out_a got %h want 00", a_out_a); end
      end
      if (c == 6) begin
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid in_ready got %b want 1", a_in_ready); end
        checks++; if (a_layer_rst !== 1'b0) begin errors++; $display("FAIL reset_mid release layer_rst got %b want 0", a_layer_rst); end
        checks++; if (a_layer_x !== 8'h00) begin errors++; $display("FAIL reset_mid held x0 got %h want 00", a_layer_x); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mux();
    test_backpressure();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_driver.md
LAYER_DRIVER -- requirements
Module: layer_driver

Interface
REQ-001 Parameter WIDTH, default 8: signed data width of layer inputs and activation.
REQ-002 Parameter CLR_CYCLES, default 2: cycles layer_rst is held before each sample (range 1..15).
REQ-003 Parameter TIMEOUT, default 255: maximum RUN cycles awaiting layer_ack (range 1..65535).
REQ-004 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: upstream sample valid.
REQ-007 Port in_ready, output, 1: driver can accept a sample.
REQ-008 Ports in_x0, in_x1, input, WIDTH signed: sample operands.
REQ-009 Port layer_req, output, 1: request to layer, held until ack or abort.
REQ-010 Port layer_rst, output, 1: synchronous active-high clear to the layer.
REQ-011 Port layer_idx, input, 1: operand index driven by the layer.
REQ-012 Port layer_x, output, WIDTH signed: operand selected by layer_idx.
REQ-013 Port layer_ack, input, 1: layer result valid; level, stays high until layer cleared.
REQ-014 Port layer_a, input, WIDTH signed: layer activation.
REQ-015 Ports out_valid, output, 1 / out_ready, input, 1: downstream result handshake.
REQ-016 Port out_a, output, WIDTH signed: captured activation.
REQ-017 Port timeout_err, output, 1: sticky; set on timeout, cleared on next accepted sample.
REQ-018 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, RUN, OUT, ABORT.
REQ-020 IDLE: in_ready=1; if in_valid is high, capture in_x0/in_x1, clear timeout_err, go to CLEAR.
REQ-021 in_ready SHALL be 0 in every state other than IDLE; accepted samples are never overwritten.
REQ-022 CLEAR: layer_rst=1 for exactly CLR_CYCLES cycles, then go to RUN; layer_ack SHALL be ignored in CLEAR.
REQ-023 RUN: layer_req=1; a 16-bit cycle counter starts at 1 on the first RUN cycle and increments each cycle.
REQ-024 RUN with layer_ack=1: capture layer_a into out_a, drop layer_req next cycle, go to OUT.
REQ-025 RUN with counter==TIMEOUT and layer_ack=0: set timeout_err, go to ABORT; if ack and timeout coincide, ack SHALL win.
REQ-026 ABORT: layer_rst=1 for CLR_CYCLES cycles, layer_req=0, then go to IDLE; out_valid SHALL NOT assert.
REQ-027 OUT: out_valid=1 and out_a stable until out_ready=1; on that cycle go to IDLE.
REQ-028 The first sample SHALL be accepted no earlier than the cycle after the OUT handshake (no IDLE bypass).
REQ-029 layer_x SHALL be combinational: held x0 when layer_idx=0, held x1 when layer_idx=1, valid in all states.
REQ-030 Latency SHALL be: sample accepted at cycle 0, layer_rst in cycles 1..CLR_CYCLES, layer_req from cycle CLR_CYCLES+1.
REQ-031 No arithmetic SHALL be applied to layer_a; WIDTH bits SHALL be passed unchanged, including sign.

Reset
REQ-032 With rst=0: state=IDLE, layer_rst=1, layer_req=0, out_valid=0, in_ready=0, out_a=0, held operands=0, timeout_err=0, counter=0.
REQ-033 On the first clk after rst deasserts: layer_rst=0 and in_ready=1.
REQ-034 An assertion of rst mid-operation SHALL abort immediately to the reset values; the pending result SHALL be discarded.

Verification
REQ-035 Basic: with layer model acking 6 cycles after req with layer_a=0x2A, send x0=16, x1=-8 -> layer_rst high for cycles 1-2, layer_req from cycle 3, out_a=0x2A with out_valid at cycle 10.
REQ-036 Operand mux: layer_idx toggles 0/1 during RUN with x0=0x10, x1=0xF8 -> layer_x follows 0x10/0xF8 with zero-cycle lag.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_a stay stable, in_ready=0, and an in_valid pulse is not accepted; release -> IDLE.
REQ-038 Timeout: TIMEOUT=4 with layer never acking -> timeout_err set at the 4th RUN cycle, ABORT for 2 cycles, no out_valid, IDLE; the next sample clears timeout_err.
REQ-039 Coincidence: TIMEOUT=4 with ack on the 4th RUN cycle -> OUT with captured value, timeout_err stays 0.
REQ-040 Reset mid-RUN: rst=0 on the 2nd RUN cycle -> layer_req=0 and layer_rst=1 immediately (asynchronous); after release, no out_valid and in_ready=1.
